// File: rtl/memory_pkg.sv
// Shared load/store definitions: word-type codes, LSU FSM encoding, bus width defaults.
// Also used by the memory_interface side and the future instruction-fetch unit.
package memory_pkg;

  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_DATA_W = 32;

  localparam logic [1:0] BYTE     = 2'b00;
  localparam logic [1:0] HALFWORD = 2'b01;
  localparam logic [1:0] WORD     = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and memory_interface strobe bundle for the LSU.
// master = pipeline plus memory side, slave = the load_store_unit itself.
interface load_store_unit_if #(
  parameter int ADDR_W = memory_pkg::DEFAULT_ADDR_W,
  parameter int DATA_W = memory_pkg::DEFAULT_DATA_W,
  parameter int TAG_W  = 4
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [1:0]        req_word_type;
  logic              req_signed;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_offset;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_error;
  logic [TAG_W-1:0]  resp_tag;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_load;
  logic              mem_store;
  logic              mem_is_signed;
  logic [1:0]        mem_word_type;
  logic              mem_busy;
  logic              mem_output_valid;
  logic              mem_write_ready;

  modport master (
    output req_valid, req_is_store, req_word_type, req_signed, req_base, req_offset,
           req_wdata, req_tag, mem_data_in, mem_busy, mem_output_valid, mem_write_ready,
    input  req_ready, resp_valid, resp_data, resp_error, resp_tag, mem_address,
           mem_data_out, mem_load, mem_store, mem_is_signed, mem_word_type
  );

  modport slave (
    input  req_valid, req_is_store, req_word_type, req_signed, req_base, req_offset,
           req_wdata, req_tag, mem_data_in, mem_busy, mem_output_valid, mem_write_ready,
    output req_ready, resp_valid, resp_data, resp_error, resp_tag, mem_address,
           mem_data_out, mem_load, mem_store, mem_is_signed, mem_word_type
  );
endinterface

// File: rtl/lsu_align_check.sv
// Combinational alignment check of an effective address against the access size.
// Zero latency; no handshake. Illegal type 2'b11 always reports misaligned.
module lsu_align_check
  import memory_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [ADDR_W-1:0] ea,
  input  logic [1:0]        word_type,
  output logic              misaligned
);
  logic unused_ea_hi;
  assign unused_ea_hi = ^ea[ADDR_W-1:2];

  always_comb begin
    misaligned = 1'b0;
    case (word_type)
      BYTE:     misaligned = 1'b0;
      HALFWORD: misaligned = ea[0];
      WORD:     misaligned = (ea[1:0] != 2'b00);
      default:  misaligned = 1'b1;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// One-at-a-time load/store initiator: error response 1 cycle after accept, else strobe then wait.
// req_ready only in IDLE; ISSUE stalls on mem_busy; a bounded timeout forces an error response.
module load_store_unit
  import memory_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ea, addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        type_q;
  logic              signed_q, store_q;
  logic [TAG_W-1:0]  tag_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              misaligned, accept, done, tmo_hit, strobe, to_respond;
  logic              resp_err_d, resp_err_q;
  logic [DATA_W-1:0] resp_data_d, resp_data_q;
  logic [TAG_W-1:0]  resp_tag_d, resp_tag_q;

  assign ea = bus.req_base + bus.req_offset;

  lsu_align_check #(.ADDR_W(ADDR_W)) u_align (
    .ea         (ea),
    .word_type  (bus.req_word_type),
    .misaligned (misaligned)
  );

  assign accept = bus.req_valid && (state_q == IDLE);
  assign done   = (state_q == WAIT) && (store_q ? bus.mem_write_ready : bus.mem_output_valid);
  // Compared against the post-increment count so the error lands within TIMEOUT_CYCLES of accept.
  assign tmo_hit = ((state_q == ISSUE) || (state_q == WAIT)) &&
                   ((tmo_cnt + TMO_W'(1)) == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    strobe      = 1'b0;
    to_respond  = 1'b0;
    resp_err_d  = 1'b0;
    resp_data_d = '0;
    resp_tag_d  = tag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_d    = RESPOND;
            to_respond = 1'b1;
            resp_err_d = 1'b1;
            resp_tag_d = bus.req_tag;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (tmo_hit) begin
          state_d    = RESPOND;
          to_respond = 1'b1;
          resp_err_d = 1'b1;
        end else if (!bus.mem_busy) begin
          strobe  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (done) begin
          state_d     = RESPOND;
          to_respond  = 1'b1;
          resp_data_d = store_q ? '0 : bus.mem_data_in;
        end else if (tmo_hit) begin
          state_d    = RESPOND;
          to_respond = 1'b1;
          resp_err_d = 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tmo_cnt <= '0;
      end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      type_q   <= '0;
      signed_q <= 1'b0;
      store_q  <= 1'b0;
      tag_q    <= '0;
    end else if (accept) begin
      addr_q   <= ea;
      wdata_q  <= bus.req_wdata;
      type_q   <= bus.req_word_type;
      signed_q <= bus.req_signed;
      store_q  <= bus.req_is_store;
      tag_q    <= bus.req_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else if (to_respond) begin
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
      resp_tag_q  <= resp_tag_d;
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.resp_valid    = (state_q == RESPOND);
  assign bus.resp_error    = resp_err_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_tag      = resp_tag_q;
  assign bus.mem_address   = addr_q;
  assign bus.mem_data_out  = wdata_q;
  assign bus.mem_word_type = type_q;
  assign bus.mem_is_signed = signed_q;
  assign bus.mem_load      = strobe && !store_q;
  assign bus.mem_store     = strobe && store_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT_CYCLES=8; inputs driven 1ns after posedge,
// outputs sampled on negedge, strobe/response pulses counted on posedge.
module tb_load_store_unit;
  import memory_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) bus ();

  load_store_unit #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int n_load   = 0;
  int n_store  = 0;
  int n_resp   = 0;

  always @(posedge clk) begin
    if (bus.mem_load)   n_load++;
    if (bus.mem_store)  n_store++;
    if (bus.resp_valid) n_resp++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_valid        = 1'b0;
    bus.req_is_store     = 1'b0;
    bus.req_word_type    = 2'b00;
    bus.req_signed       = 1'b0;
    bus.req_base         = '0;
    bus.req_offset       = '0;
    bus.req_wdata        = '0;
    bus.req_tag          = '0;
    bus.mem_data_in      = '0;
    bus.mem_busy         = 1'b0;
    bus.mem_output_valid = 1'b0;
    bus.mem_write_ready  = 1'b0;
  endtask

  task automatic drive_req(input logic st, input logic [1:0] wt, input logic sg,
                           input logic [AW-1:0] base, input logic [AW-1:0] off,
                           input logic [DW-1:0] wd, input logic [TW-1:0] tag);
    bus.req_valid     = 1'b1;
    bus.req_is_store  = st;
    bus.req_word_type = wt;
    bus.req_signed    = sg;
    bus.req_base      = base;
    bus.req_offset    = off;
    bus.req_wdata     = wd;
    bus.req_tag       = tag;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_error, bus.mem_load, bus.mem_store, bus.mem_is_signed} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=100000",
               {bus.req_ready, bus.resp_valid, bus.resp_error, bus.mem_load, bus.mem_store, bus.mem_is_signed});
    end
    checks++;
    if ({bus.mem_address, bus.resp_data, bus.mem_data_out, bus.resp_tag, bus.mem_word_type} !== '0) begin
      failures++;
      $display("FAIL reset_buses addr=%h rdata=%h wdata=%h tag=%h wt=%b exp all 0",
               bus.mem_address, bus.resp_data, bus.mem_data_out, bus.resp_tag, bus.mem_word_type);
    end
    #20 reset = 1'b1;
  endtask

  task automatic test_load_word();
    int l0, s0;
    cyc();
    drive_req(1'b0, WORD, 1'b0, 12'h100, 12'h004, 32'h0, 4'h3);
    l0 = n_load; s0 = n_store;
    smp();
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL lw_accept_ready got=%b exp=1", bus.req_ready); end
    cyc();
    bus.req_valid = 1'b0;
    smp();
    checks++;
    if ({bus.mem_load, bus.mem_store, bus.mem_word_type, bus.mem_address} !== {1'b1, 1'b0, 2'b10, 12'h104}) begin
      failures++;
      $display("FAIL lw_strobe load=%b store=%b wt=%b addr=%h exp 1 0 10 104",
               bus.mem_load, bus.mem_store, bus.mem_word_type, bus.mem_address);
    end
    checks++;
    if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL lw_busy_ready got=%b exp=0", bus.req_ready); end
    cyc();
    bus.mem_write_ready = 1'b1;
    smp();
    checks++;
    if ({bus.mem_load, bus.resp_valid} !== 2'b00) begin
      failures++;
      $display("FAIL lw_wait_quiet load=%b resp=%b exp 0 0", bus.mem_load, bus.resp_valid);
    end
    cyc();
    bus.mem_write_ready  = 1'b0;
    bus.mem_output_valid = 1'b1;
    bus.mem_data_in      = 32'hDEADBEEF;
    smp();
    checks++;
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL lw_ignore_wr got=%b exp=0", bus.resp_valid); end
    cyc();
    bus.mem_output_valid = 1'b0;
    bus.mem_data_in      = 32'h0;
    smp();
    checks++;
    if ({bus.resp_valid, bus.resp_error, bus.resp_tag, bus.resp_data} !== {1'b1, 1'b0, 4'h3, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL lw_resp valid=%b err=%b tag=%h data=%h exp 1 0 3 deadbeef",
               bus.resp_valid, bus.resp_error, bus.resp_tag, bus.resp_data);
    end
    cyc();
    smp();
    checks++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL lw_after valid=%b ready=%b exp 0 1", bus.resp_valid, bus.req_ready);
    end
    checks++;
    if ((n_load - l0) != 1 || (n_store - s0) != 0) begin
      failures++;
      $display("FAIL lw_pulses loads=%0d stores=%0d exp 1 0", n_load - l0, n_store - s0);
    end
  endtask

  task automatic test_store_half_busy();
    int s0;
    cyc();
    drive_req(1'b1, HALFWORD, 1'b0, 12'h200, 12'h002, 32'h0000ABCD, 4'h9);
    bus.mem_busy = 1'b1;
    s0 = n_store;
    smp();
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.req_valid = 1'b0;
      smp();
      checks++;
      if ({bus.mem_store, bus.mem_load} !== 2'b00) begin
        failures++;
        $display("FAIL st_busy_no_strobe cyc=%0d store=%b load=%b exp 0 0", i, bus.mem_store, bus.mem_load);
      end
    end
    cyc();
    bus.mem_busy = 1'b0;
    smp();
    checks++;
    if ({bus.mem_store, bus.mem_word_type, bus.mem_address, bus.mem_data_out} !== {1'b1, 2'b01, 12'h202, 32'h0000ABCD}) begin
      failures++;
      $display("FAIL st_strobe store=%b wt=%b addr=%h dout=%h exp 1 01 202 0000abcd",
               bus.mem_store, bus.mem_word_type, bus.mem_address, bus.mem_data_out);
    end
    cyc();
    bus.mem_write_ready = 1'b1;
    smp();
    checks++;
    if (bus.mem_store !== 1'b0) begin failures++; $display("FAIL st_single_strobe got=%b exp=0", bus.mem_store); end
    cyc();
    bus.mem_write_ready = 1'b0;
    smp();
    checks++;
    if ({bus.resp_valid, bus.resp_error, bus.resp_tag, bus.resp_data} !== {1'b1, 1'b0, 4'h9, 32'h0}) begin
      failures++;
      $display("FAIL st_resp valid=%b err=%b tag=%h data=%h exp 1 0 9 0",
               bus.resp_valid, bus.resp_error, bus.resp_tag, bus.resp_data);
    end
    cyc();
    smp();
    checks++;
    if ((n_store - s0) != 1) begin failures++; $display("FAIL st_pulses got=%0d exp=1", n_store - s0); end
  endtask

  task automatic test_misaligned();
    int l0, s0;
    cyc();
    drive_req(1'b0, WORD, 1'b0, 12'h000, 12'h006, 32'h0, 4'hA);
    l0 = n_load; s0 = n_store;
    smp();
    cyc();
    bus.req_valid = 1'b0;
    smp();
    checks++;
    if ({bus.resp_valid, bus.resp_error, bus.resp_tag, bus.resp_data, bus.mem_load} !== {1'b1, 1'b1, 4'hA, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL mis_word_resp valid=%b err=%b tag=%h data=%h load=%b exp 1 1 a 0 0",
               bus.resp_valid, bus.resp_error, bus.resp_tag, bus.resp_data, bus.mem_load);
    end
    cyc();
    drive_req(1'b0, 2'b11, 1'b0, 12'h000, 12'h000, 32'h0, 4'h5);
    smp();
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL ill_ready got=%b exp=1", bus.req_ready); end
    cyc();
    bus.req_valid = 1'b0;
    smp();
    checks++;
    if ({bus.resp_valid, bus.resp_error, bus.resp_tag} !== {1'b1, 1'b1, 4'h5}) begin
      failures++;
      $display("FAIL ill_type_resp valid=%b err=%b tag=%h exp 1 1 5", bus.resp_valid, bus.resp_error, bus.resp_tag);
    end
    cyc();
    smp();
    checks++;
    if ((n_load - l0) != 0 || (n_store - s0) != 0 || bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mis_no_strobe loads=%0d stores=%0d resp=%b exp 0 0 0", n_load - l0, n_store - s0, bus.resp_valid);
    end
  endtask

  task automatic test_wrap_signed();
    cyc();
    drive_req(1'b0, BYTE, 1'b1, 12'hFFE, 12'h003, 32'h0, 4'h6);
    smp();
    cyc();
    bus.req_valid = 1'b0;
    smp();
    checks++;
    if ({bus.mem_load, bus.mem_is_signed, bus.mem_word_type, bus.mem_address} !== {1'b1, 1'b1, 2'b00, 12'h001}) begin
      failures++;
      $display("FAIL wrap_strobe load=%b signed=%b wt=%b addr=%h exp 1 1 00 001",
               bus.mem_load, bus.mem_is_signed, bus.mem_word_type, bus.mem_address);
    end
    cyc();
    bus.mem_output_valid = 1'b1;
    bus.mem_data_in      = 32'hFFFFFF80;
    smp();
    cyc();
    bus.mem_output_valid = 1'b0;
    bus.mem_data_in      = 32'h0;
    smp();
    checks++;
    if ({bus.resp_valid, bus.resp_error, bus.resp_tag, bus.resp_data} !== {1'b1, 1'b0, 4'h6, 32'hFFFFFF80}) begin
      failures++;
      $display("FAIL wrap_resp valid=%b err=%b tag=%h data=%h exp 1 0 6 ffffff80",
               bus.resp_valid, bus.resp_error, bus.resp_tag, bus.resp_data);
    end
  endtask

  task automatic test_timeout();
    int l0, lat;
    bit got;
    lat = 0; got = 1'b0;
    cyc();
    drive_req(1'b0, WORD, 1'b0, 12'h010, 12'h000, 32'h0, 4'hC);
    l0 = n_load;
    smp();
    cyc();
    bus.req_valid   = 1'b0;
    bus.mem_data_in = 32'h12345678;
    for (int k = 1; k <= 12; k++) begin
      smp();
      if (bus.resp_valid === 1'b1) begin
        got = 1'b1;
        lat = k;
        break;
      end
      cyc();
    end
    checks++;
    if (!got || lat != 8) begin
      failures++;
      $display("FAIL tmo_latency seen=%0d cycles=%0d exp seen=1 cycles=8", got, lat);
    end
    checks++;
    if ({bus.resp_error, bus.resp_tag, bus.resp_data} !== {1'b1, 4'hC, 32'h0}) begin
      failures++;
      $display("FAIL tmo_resp err=%b tag=%h data=%h exp 1 c 0", bus.resp_error, bus.resp_tag, bus.resp_data);
    end
    cyc();
    bus.mem_data_in = 32'h0;
    smp();
    checks++;
    if (bus.req_ready !== 1'b1 || (n_load - l0) != 1) begin
      failures++;
      $display("FAIL tmo_after ready=%b loads=%0d exp 1 1", bus.req_ready, n_load - l0);
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    drive_req(1'b0, HALFWORD, 1'b0, 12'h001, 12'h000, 32'h0, 4'h1);
    smp();
    cyc();
    drive_req(1'b1, BYTE, 1'b0, 12'h040, 12'h001, 32'h0000005A, 4'h2);
    smp();
    checks++;
    if ({bus.resp_valid, bus.resp_error, bus.req_ready} !== 3'b110) begin
      failures++;
      $display("FAIL b2b_first valid=%b err=%b ready=%b exp 1 1 0", bus.resp_valid, bus.resp_error, bus.req_ready);
    end
    cyc();
    smp();
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept_ready got=%b exp=1", bus.req_ready); end
    cyc();
    bus.req_valid = 1'b0;
    smp();
    checks++;
    if ({bus.mem_store, bus.mem_address, bus.mem_data_out} !== {1'b1, 12'h041, 32'h0000005A}) begin
      failures++;
      $display("FAIL b2b_strobe store=%b addr=%h dout=%h exp 1 041 0000005a", bus.mem_store, bus.mem_address, bus.mem_data_out);
    end
    cyc();
    bus.mem_write_ready = 1'b1;
    smp();
    cyc();
    bus.mem_write_ready = 1'b0;
    smp();
    checks++;
    if ({bus.resp_valid, bus.resp_error, bus.resp_tag} !== {1'b1, 1'b0, 4'h2}) begin
      failures++;
      $display("FAIL b2b_resp valid=%b err=%b tag=%h exp 1 0 2", bus.resp_valid, bus.resp_error, bus.resp_tag);
    end
  endtask

  task automatic test_reset_in_wait();
    int r0;
    cyc();
    drive_req(1'b0, WORD, 1'b0, 12'h300, 12'h000, 32'h0, 4'h7);
    smp();
    cyc();
    bus.req_valid = 1'b0;
    smp();
    cyc();
    smp();
    #2 reset = 1'b0;
    #1;
    r0 = n_resp;
    checks++;
    if ({bus.req_ready, bus.mem_load, bus.mem_store, bus.resp_valid} !== 4'b1000) begin
      failures++;
      $display("FAIL rst_wait_flags ready=%b load=%b store=%b resp=%b exp 1 0 0 0",
               bus.req_ready, bus.mem_load, bus.mem_store, bus.resp_valid);
    end
    checks++;
    if ({bus.mem_address, bus.mem_word_type, bus.resp_tag} !== '0) begin
      failures++;
      $display("FAIL rst_wait_regs addr=%h wt=%b tag=%h exp 0 0 0", bus.mem_address, bus.mem_word_type, bus.resp_tag);
    end
    cyc();
    cyc();
    smp();
    reset = 1'b1;
    cyc();
    bus.mem_output_valid = 1'b1;
    bus.mem_data_in      = 32'hCAFEF00D;
    cyc();
    bus.mem_output_valid = 1'b0;
    bus.mem_data_in      = 32'h0;
    cyc();
    cyc();
    smp();
    checks++;
    if ((n_resp - r0) != 0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_late_valid resps=%0d ready=%b exp 0 1", n_resp - r0, bus.req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_half_busy();
    test_misaligned();
    test_wrap_signed();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator-side engine that drives the memory_interface load/store handshake on behalf of the CPU pipeline.
- Accepts one load or store request at a time and forms the effective 12-bit address (base + offset).
- Checks alignment, issues a single-cycle load/store strobe, and waits for output_valid or write_ready.
- Returns a one-cycle response (data or error) to writeback.

Parameters:
ADDR_W, 12, address width; matches memory_interface address.
DATA_W, 32, data width.
TAG_W, 4, destination-register tag width.
TIMEOUT_CYCLES, 255, cycles spent in ISSUE+WAIT before an error is forced.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  pipeline request present.
req_ready  output  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high.
req_is_store  input  1  1 = store, 0 = load.
req_word_type  input  2  BYTE=00, HALFWORD=01, WORD=10, 11 is illegal.
req_signed  input  1  sign-extend the load result.
req_base  input  ADDR_W  base address.
req_offset  input  ADDR_W  offset, two's complement.
req_wdata  input  DATA_W  store data, right-aligned.
req_tag  input  TAG_W  destination tag, echoed in the response.
resp_valid  output  1  one-cycle completion pulse.
resp_data  output  DATA_W  load data; 0 for stores and errors.
resp_error  output  1  misaligned access, illegal type, or timeout.
resp_tag  output  TAG_W  tag of the completed request.
mem_address  output  ADDR_W  to memory_interface address.
mem_data_out  output  DATA_W  to memory_interface data_in.
mem_data_in  input  DATA_W  from memory_interface data_out.
mem_load  output  1  load strobe.
mem_store  output  1  store strobe.
mem_is_signed  output  1  to is_signed.
mem_word_type  output  2  to word_type.
mem_busy  input  1  memory_interface busy.
mem_output_valid  input  1  load data valid.
mem_write_ready  input  1  store complete.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, timeout counter=0, all outputs 0 except req_ready=1. A reset asserted mid-transaction abandons it with no response; mem_load and mem_store drop immediately.
- Effective address: ea = (req_base + req_offset) mod 2^ADDR_W. Wrap-around is legal, e.g. 0xFFC + 0x008 = 0x004.
- Alignment:
  - WORD requires ea[1:0]=00.
  - HALFWORD requires ea[0]=0.
  - BYTE is always aligned.
  - Type 11 is always an error.
- Request registers: address, data, type, signed, store and tag are captured on acceptance and held stable on the mem_* outputs until the next acceptance.
- States:
  - IDLE: on acceptance, go to RESPOND with error=1 if the check fails; otherwise go to ISSUE.
  - ISSUE: while mem_busy=1, stay. When mem_busy=0, assert mem_load or mem_store for exactly this one cycle, then go to WAIT.
  - WAIT: completion is mem_output_valid for a load, mem_write_ready for a store; the other flag is ignored. On completion, capture mem_data_in (loads only) and go to RESPOND. Completion flags are sampled only in WAIT, never in the strobe cycle.
  - RESPOND: resp_valid=1 for one cycle with resp_data, resp_error and resp_tag registered, then go to IDLE.
- Timeout: the counter clears on acceptance and increments every cycle in ISSUE or WAIT. When it reaches TIMEOUT_CYCLES-1 without completion, go to RESPOND with error=1 and data=0, and issue no further strobe. Completion and timeout in the same cycle: completion wins.
- Latency:
  - Error response: accept at cycle N, resp_valid at N+1.
  - Normal path with mem_busy low: accept at N, strobe at N+1, first completion sample at N+2, completion at cycle M, resp_valid at M+1.
- Back-to-back: req_ready is low in ISSUE, WAIT and RESPOND. The next request can be accepted in the cycle after the RESPOND pulse.
- resp_data holds its last value between pulses; consumers qualify it with resp_valid.

Decomposition:
- Shared package memory_pkg:
  - word-type constants BYTE=2'b00, HALFWORD=2'b01, WORD=2'b10;
  - FSM state encoding IDLE/ISSUE/WAIT/RESPOND;
  - ADDR_W and DATA_W defaults.
- One sub-module, lsu_align_check: combinational; inputs ea and word_type, output misaligned. It is shared with the future instruction-fetch unit.

Test Plan:
- Load WORD, base 0x100, offset 0x004, tag 3, memory returns output_valid with 0xDEADBEEF 2 cycles after the strobe -> one mem_load pulse with mem_address=0x104 and word_type=10; then resp_valid for one cycle with data 0xDEADBEEF, tag 3, error 0.
- Store HALFWORD 0x0000ABCD to ea 0x202 with mem_busy held high for 3 cycles -> no strobe while busy, then exactly one mem_store pulse once busy drops; write_ready gives resp_valid with data 0 and error 0.
- Load WORD at ea 0x006 -> no mem_load or mem_store; resp_valid with error=1 one cycle after acceptance. Repeat with word_type=11, same result.
- Wrap: base 0xFFE, offset 0x003, BYTE load -> mem_address=0x001; signed=1 propagates to mem_is_signed.
- Timeout with TIMEOUT_CYCLES=8: load issued, no output_valid -> resp_valid with error=1 and data=0 no more than 8 cycles after acceptance; req_ready returns to 1 afterwards.
- Reset pulled low during WAIT -> all outputs 0 and req_ready=1 immediately; no resp_valid; a late output_valid after reset release produces no response.
